// File: rtl/my_mux_4_way_block.sv
// Four-way data selector with a combinational result and an enable-gated,
// synchronously reset registered copy of that result.
module my_mux_4_way_block #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       sel,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic [1:0]       sel_q,
  output logic             out_vld
);

  logic [WIDTH-1:0] out_d;
  logic [1:0]       sel_d;
  logic             vld_d;

  // Select one input; an undefined select propagates X rather than
  // silently picking an input.
  always_comb begin
    unique case (sel)
      2'b00:   out = a;
      2'b01:   out = b;
      2'b10:   out = c;
      2'b11:   out = d;
      default: out = {WIDTH{1'bx}};
    endcase
  end

  // Next state for the registered path: load on enable, otherwise hold.
  always_comb begin
    out_d = out_q;
    sel_d = sel_q;
    vld_d = out_vld;
    if (en) begin
      out_d = out;
      sel_d = sel;
      vld_d = 1'b1;
    end
  end

  // Registered result; reset wins over enable on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q   <= '0;
      sel_q   <= 2'b00;
      out_vld <= 1'b0;
    end else begin
      out_q   <= out_d;
      sel_q   <= sel_d;
      out_vld <= vld_d;
    end
  end

endmodule

// File: tb/tb_my_mux_4_way_block.sv
// Self-checking bench: vector table for the selector, hand sequences for the
// registered path and reset, then randomized stimulus against a model.
module tb_my_mux_4_way_block;

  localparam int unsigned W = 16;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] a, b, c, d;
  logic [1:0]   sel;
  logic         en;
  logic [W-1:0] out;
  logic [W-1:0] out_q;
  logic [1:0]   sel_q;
  logic         out_vld;

  int checks;
  int errors;

  my_mux_4_way_block #(
    .WIDTH(W)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a),
    .b      (b),
    .c      (c),
    .d      (d),
    .sel    (sel),
    .en     (en),
    .out    (out),
    .out_q  (out_q),
    .sel_q  (sel_q),
    .out_vld(out_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   sel;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    logic [W-1:0] d;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[8];

  // Reference selection: index an array of the four inputs by the select code.
  function automatic logic [W-1:0] pick(input logic [1:0] s, input logic [W-1:0] ia,
                                        input logic [W-1:0] ib, input logic [W-1:0] ic,
                                        input logic [W-1:0] id);
    logic [W-1:0] arr [4];
    arr[0] = ia;
    arr[1] = ib;
    arr[2] = ic;
    arr[3] = id;
    return arr[s];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model state for the registered path.
  logic [W-1:0] m_q;
  logic [1:0]   m_sel;
  logic         m_vld;
  logic [W-1:0] m_out;

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    en     = 1'b1;
    sel    = 2'b00;
    a = 16'h8000; b = 16'h0800; c = 16'h0080; d = 16'h0008;

    vecs[0] = '{2'b00, 16'h8000, 16'h0800, 16'h0080, 16'h0008, 16'h8000};
    vecs[1] = '{2'b01, 16'h8000, 16'h0800, 16'h0080, 16'h0008, 16'h0800};
    vecs[2] = '{2'b10, 16'h8000, 16'h0800, 16'h0080, 16'h0008, 16'h0080};
    vecs[3] = '{2'b11, 16'h8000, 16'h0800, 16'h0080, 16'h0008, 16'h0008};
    vecs[4] = '{2'b00, 16'hffff, 16'h0000, 16'h0000, 16'h0000, 16'hffff};
    vecs[5] = '{2'b11, 16'h0000, 16'h0000, 16'h0000, 16'hffff, 16'hffff};
    vecs[6] = '{2'b01, 16'h1234, 16'ha5a5, 16'h5a5a, 16'hdead, 16'ha5a5};
    vecs[7] = '{2'b10, 16'h1234, 16'ha5a5, 16'h5a5a, 16'hdead, 16'h5a5a};

    // Reset held with en high: registered outputs clear, out still live.
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_q", 64'(out_q), 64'h0);
    check("reset_sel_q", 64'(sel_q), 64'h0);
    check("reset_vld", 64'(out_vld), 64'h0);
    check("reset_out_comb", 64'(out), 64'h8000);

    // Release reset with en low: nothing may load.
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b0;
    sel   = 2'b01;
    @(posedge clk); #1;
    check("release_no_load_vld", 64'(out_vld), 64'h0);
    check("release_no_load_q", 64'(out_q), 64'h0);

    // Combinational selection table; en low so registers stay put.
    foreach (vecs[i]) begin
      @(negedge clk);
      sel = vecs[i].sel;
      a = vecs[i].a; b = vecs[i].b; c = vecs[i].c; d = vecs[i].d;
      #10;
      check($sformatf("vec%0d_out", i), 64'(out), 64'(vecs[i].exp));
    end
    check("table_vld_held", 64'(out_vld), 64'h0);

    // Single enabled load of sel=10.
    @(negedge clk);
    a = 16'h8000; b = 16'h0800; c = 16'h0080; d = 16'h0008;
    sel = 2'b10;
    en  = 1'b1;
    @(posedge clk); #1;
    check("load_out_q", 64'(out_q), 64'h0080);
    check("load_sel_q", 64'(sel_q), 64'h2);
    check("load_vld", 64'(out_vld), 64'h1);

    // Disable, change sel: out follows at once, out_q holds for 3 edges.
    @(negedge clk);
    en  = 1'b0;
    sel = 2'b11;
    #1;
    check("hold_out_comb", 64'(out), 64'h0008);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("hold_out_q_%0d", k), 64'(out_q), 64'h0080);
      check($sformatf("hold_sel_q_%0d", k), 64'(sel_q), 64'h2);
    end

    // Mid-operation reset with en high: reset takes priority.
    @(negedge clk);
    rst_n = 1'b0;
    en    = 1'b1;
    @(posedge clk); #1;
    check("midrst_out_q", 64'(out_q), 64'h0);
    check("midrst_sel_q", 64'(sel_q), 64'h0);
    check("midrst_vld", 64'(out_vld), 64'h0);
    sel = 2'b01;
    #1;
    check("midrst_out_comb", 64'(out), 64'h0800);

    // First edge with rst_n high and en high loads immediately.
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_load_q", 64'(out_q), 64'h0800);
    check("post_rst_load_vld", 64'(out_vld), 64'h1);

    // Randomized run against the model.
    m_q   = out_q;
    m_sel = sel_q;
    m_vld = out_vld;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      a     = W'($urandom);
      b     = W'($urandom);
      c     = W'($urandom);
      d     = W'($urandom);
      sel   = 2'($urandom_range(0, 3));
      en    = 1'($urandom_range(0, 1));
      rst_n = ($urandom_range(0, 49) != 0);
      #1;
      m_out = pick(sel, a, b, c, d);
      check("rand_out", 64'(out), 64'(m_out));
      @(posedge clk);
      if (!rst_n) begin
        m_q = '0; m_sel = 2'b00; m_vld = 1'b0;
      end else if (en) begin
        m_q = m_out; m_sel = sel; m_vld = 1'b1;
      end
      #1;
      check("rand_out_q", 64'(out_q), 64'(m_q));
      check("rand_sel_q", 64'(sel_q), 64'(m_sel));
      check("rand_vld", 64'(out_vld), 64'(m_vld));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
